// File: rtl/id_stage_piped.sv
// id_stage_piped: decode stage with integrated ID/EX pipeline register.
//
// Decodes an ARM-style instruction word, reads a REG_CNT-entry register file
// (with write-through bypass from WB) and registers the decode result for EX.
// The ID/EX register can hold (stall), load a bubble (flush / hazard / failed
// condition) or load a live instruction.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, PC_in,
//   instruction               IF/ID contents
//   stall, flush, hazard      pipeline control
//   Z, N, C, V                status flags for condition evaluation
//   write_back, dest_wb,
//   result_wb                 WB write port into the register file
//   src1, src2, two_src       combinational source info for the hazard unit
//   ex_*                      registered ID/EX outputs
//
// Decode map (exec_cmd):
//   mode 00 data-processing: MOV 0001, MVN 1001, ADD 0010, ADC 0011,
//     SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000 (all write back),
//     CMP 0100, TST 0110 (no write back); other opcodes decode to nothing.
//     S follows instruction[20].
//   mode 01 memory: exec 0010; L=1 -> LDR (mem_read, wb), L=0 -> STR.
//   mode 10 branch: B=1.
//   imm always follows instruction[25].

module control_unit (
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_in,
  input  logic       i_in,
  output logic [3:0] exec_cmd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_en,
  output logic       b,
  output logic       s,
  output logic       imm
);
  always_comb begin
    exec_cmd  = 4'b0000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_en     = 1'b0;
    b         = 1'b0;
    s         = 1'b0;
    imm       = i_in;
    case (mode)
      2'b00: begin
        s = s_in;
        case (opcode)
          4'b1101: begin exec_cmd = 4'b0001; wb_en = 1'b1; end // MOV
          4'b1111: begin exec_cmd = 4'b1001; wb_en = 1'b1; end // MVN
          4'b0100: begin exec_cmd = 4'b0010; wb_en = 1'b1; end // ADD
          4'b0101: begin exec_cmd = 4'b0011; wb_en = 1'b1; end // ADC
          4'b0010: begin exec_cmd = 4'b0100; wb_en = 1'b1; end // SUB
          4'b0110: begin exec_cmd = 4'b0101; wb_en = 1'b1; end // SBC
          4'b0000: begin exec_cmd = 4'b0110; wb_en = 1'b1; end // AND
          4'b1100: begin exec_cmd = 4'b0111; wb_en = 1'b1; end // ORR
          4'b0001: begin exec_cmd = 4'b1000; wb_en = 1'b1; end // EOR
          4'b1010: exec_cmd = 4'b0100;                         // CMP
          4'b1000: exec_cmd = 4'b0110;                         // TST
          default: ;
        endcase
      end
      2'b01: begin
        exec_cmd = 4'b0010;
        if (s_in) begin
          mem_read = 1'b1;
          wb_en    = 1'b1;
        end else begin
          mem_write = 1'b1;
        end
      end
      2'b10:   b = 1'b1;
      default: ;
    endcase
  end
endmodule

// Standard ARM condition codes; 1110 is always, 1111 never matches.
module condition_check (
  input  logic [3:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       c,
  input  logic       v,
  output logic       matched
);
  always_comb begin
    matched = 1'b0;
    case (cond)
      4'b0000: matched = z;
      4'b0001: matched = ~z;
      4'b0010: matched = c;
      4'b0011: matched = ~c;
      4'b0100: matched = n;
      4'b0101: matched = ~n;
      4'b0110: matched = v;
      4'b0111: matched = ~v;
      4'b1000: matched = c & ~z;
      4'b1001: matched = ~c | z;
      4'b1010: matched = (n == v);
      4'b1011: matched = (n != v);
      4'b1100: matched = ~z & (n == v);
      4'b1101: matched = z | (n != v);
      4'b1110: matched = 1'b1;
      default: matched = 1'b0;
    endcase
  end
endmodule

module id_stage_piped #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int REG_AW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              flush,
  input  logic              hazard,
  input  logic              Z,
  input  logic              N,
  input  logic              C,
  input  logic              V,
  input  logic              write_back,
  input  logic [REG_AW-1:0] dest_wb,
  input  logic [DATA_W-1:0] result_wb,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic              two_src,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_PC,
  output logic              ex_wb_en,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_B,
  output logic              ex_S,
  output logic              ex_imm,
  output logic [3:0]        ex_exec_cmd,
  output logic [DATA_W-1:0] ex_val_Rn,
  output logic [DATA_W-1:0] ex_val_Rm,
  output logic [REG_AW-1:0] ex_Rd,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_signed_imm_24,
  output logic [REG_AW-1:0] ex_src1,
  output logic [REG_AW-1:0] ex_src2
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
    logic              b;
    logic              s;
    logic              imm;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [REG_AW-1:0] rd;
    logic [11:0]       shift_operand;
    logic [23:0]       simm24;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
  } idex_t;

  // decode
  logic [3:0] cu_cmd;
  logic       cu_mem_read, cu_mem_write, cu_wb_en, cu_b, cu_s, cu_imm;
  logic       cond_matched;

  control_unit u_cu (
    .mode      (instruction[27:26]),
    .opcode    (instruction[24:21]),
    .s_in      (instruction[20]),
    .i_in      (instruction[25]),
    .exec_cmd  (cu_cmd),
    .mem_read  (cu_mem_read),
    .mem_write (cu_mem_write),
    .wb_en     (cu_wb_en),
    .b         (cu_b),
    .s         (cu_s),
    .imm       (cu_imm)
  );

  condition_check u_cc (
    .cond    (instruction[31:28]),
    .z       (Z),
    .n       (N),
    .c       (C),
    .v       (V),
    .matched (cond_matched)
  );

  // STR reads its data register from the Rd field, so the second operand
  // index moves there for stores.
  assign src1    = REG_AW'(instruction[19:16]);
  assign src2    = cu_mem_write ? REG_AW'(instruction[15:12])
                                : REG_AW'(instruction[3:0]);
  assign two_src = in_valid & (cu_mem_write | ~cu_imm);

  // register file; an out-of-range dest_wb matches no entry and is dropped
  logic [REG_CNT-1:0][DATA_W-1:0] regs;

  for (genvar g = 0; g < REG_CNT; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst)                                       regs[g] <= '0;
      else if (write_back && dest_wb == REG_AW'(g))  regs[g] <= result_wb;
    end
  end

  // write-through bypass: a same-cycle WB write is visible to the read
  logic [DATA_W-1:0] rd_rn, rd_rm;
  assign rd_rn = (write_back && dest_wb == src1) ? result_wb : regs[src1];
  assign rd_rm = (write_back && dest_wb == src2) ? result_wb : regs[src2];

  logic  live;
  idex_t dec, ex_q;

  assign live = in_valid & cond_matched & ~hazard;

  always_comb begin
    dec               = '0;
    dec.valid         = 1'b1;
    dec.pc            = PC_in;
    dec.wb_en         = cu_wb_en;
    dec.mem_read      = cu_mem_read;
    dec.mem_write     = cu_mem_write;
    dec.b             = cu_b;
    dec.s             = cu_s;
    dec.imm           = cu_imm;
    dec.cmd           = cu_cmd;
    dec.val_rn        = rd_rn;
    dec.val_rm        = rd_rm;
    dec.rd            = REG_AW'(instruction[15:12]);
    dec.shift_operand = instruction[11:0];
    dec.simm24        = instruction[23:0];
    dec.src1          = src1;
    dec.src2          = src2;
  end

  // bubbles clear the whole record, data fields included, so EX sees
  // deterministic values
  always_ff @(posedge clk) begin
    if (rst)         ex_q <= '0;
    else if (flush)  ex_q <= '0;
    else if (!stall) ex_q <= live ? dec : '0;
  end

  assign ex_valid         = ex_q.valid;
  assign ex_PC            = ex_q.pc;
  assign ex_wb_en         = ex_q.wb_en;
  assign ex_mem_read      = ex_q.mem_read;
  assign ex_mem_write     = ex_q.mem_write;
  assign ex_B             = ex_q.b;
  assign ex_S             = ex_q.s;
  assign ex_imm           = ex_q.imm;
  assign ex_exec_cmd      = ex_q.cmd;
  assign ex_val_Rn        = ex_q.val_rn;
  assign ex_val_Rm        = ex_q.val_rm;
  assign ex_Rd            = ex_q.rd;
  assign ex_shift_operand = ex_q.shift_operand;
  assign ex_signed_imm_24 = ex_q.simm24;
  assign ex_src1          = ex_q.src1;
  assign ex_src2          = ex_q.src2;

endmodule

// File: tb/tb_id_stage_piped.sv
module tb_id_stage_piped;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, stall, flush, hazard, Z, N, C, V, write_back;
  logic [31:0] PC_in, instruction, result_wb;
  logic [3:0]  dest_wb;
  logic [3:0]  src1, src2, ex_Rd, ex_src1, ex_src2, ex_exec_cmd;
  logic        two_src, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write;
  logic        ex_B, ex_S, ex_imm;
  logic [31:0] ex_PC, ex_val_Rn, ex_val_Rm;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_signed_imm_24;

  id_stage_piped dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .PC_in(PC_in),
    .instruction(instruction), .stall(stall), .flush(flush), .hazard(hazard),
    .Z(Z), .N(N), .C(C), .V(V), .write_back(write_back), .dest_wb(dest_wb),
    .result_wb(result_wb), .src1(src1), .src2(src2), .two_src(two_src),
    .ex_valid(ex_valid), .ex_PC(ex_PC), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_B(ex_B),
    .ex_S(ex_S), .ex_imm(ex_imm), .ex_exec_cmd(ex_exec_cmd),
    .ex_val_Rn(ex_val_Rn), .ex_val_Rm(ex_val_Rm), .ex_Rd(ex_Rd),
    .ex_shift_operand(ex_shift_operand), .ex_signed_imm_24(ex_signed_imm_24),
    .ex_src1(ex_src1), .ex_src2(ex_src2)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        wb, mr, mw, b, s, imm;
    logic [3:0]  cmd;
    logic [31:0] rn, rm;
    logic [3:0]  rd;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  s1, s2;
  } ex_t;

  ex_t act, exp_st, snap;
  assign act = {ex_valid, ex_PC, ex_wb_en, ex_mem_read, ex_mem_write, ex_B,
                ex_S, ex_imm, ex_exec_cmd, ex_val_Rn, ex_val_Rm, ex_Rd,
                ex_shift_operand, ex_signed_imm_24, ex_src1, ex_src2};

  logic [31:0] mreg [16];
  int n_cmp = 0, n_fail = 0;

  // data-processing opcode -> ALU command / write-back, by opcode number
  int dp_cmd [16] = '{6, 8, 4, 0, 2, 3, 5, 0, 6, 0, 4, 0, 7, 1, 0, 9};
  int dp_wb  [16] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1};

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // condition pairs: even code tests the predicate, odd code its inverse
  function automatic logic cond_ok(input logic [3:0] c);
    logic p;
    case (c[3:1])
      3'd0: p = Z;
      3'd1: p = C;
      3'd2: p = N;
      3'd3: p = V;
      3'd4: p = C && !Z;
      3'd5: p = (N == V);
      3'd6: p = !Z && (N == V);
      default: p = 1'b1;
    endcase
    return c[0] ? !p : p;
  endfunction

  function automatic logic is_store();
    return instruction[27:26] == 2'b01 && !instruction[20];
  endfunction

  function automatic logic [3:0] exp_src2();
    return is_store() ? instruction[15:12] : instruction[3:0];
  endfunction

  function automatic logic [31:0] rd_val(input logic [3:0] idx);
    return (write_back && dest_wb == idx) ? result_wb : mreg[idx];
  endfunction

  function automatic ex_t decode();
    ex_t d = '0;
    int  op = int'(instruction[24:21]);
    d.valid = 1'b1;
    d.pc    = PC_in;
    d.imm   = instruction[25];
    case (instruction[27:26])
      2'b00: begin
        d.s   = instruction[20];
        d.cmd = 4'(dp_cmd[op]);
        d.wb  = dp_wb[op] != 0;
      end
      2'b01: begin
        d.cmd = 4'd2;
        d.mr  = instruction[20];
        d.wb  = instruction[20];
        d.mw  = !instruction[20];
      end
      2'b10: d.b = 1'b1;
      default: ;
    endcase
    d.rn   = rd_val(instruction[19:16]);
    d.rm   = rd_val(exp_src2());
    d.rd   = instruction[15:12];
    d.sh   = instruction[11:0];
    d.simm = instruction[23:0];
    d.s1   = instruction[19:16];
    d.s2   = exp_src2();
    return d;
  endfunction

  // one clock: check combinational outputs, advance model, compare ID/EX
  task automatic tick();
    ex_t nxt;
    #1;
    chk("src1", src1, instruction[19:16]);
    chk("src2", src2, exp_src2());
    chk("two_src", two_src, in_valid && (is_store() || !instruction[25]));
    if (rst) begin
      nxt = '0;
      for (int i = 0; i < 16; i++) mreg[i] = '0;
    end else begin
      if (flush)                                      nxt = '0;
      else if (stall)                                 nxt = exp_st;
      else if (!(in_valid && cond_ok(instruction[31:28]) && !hazard)) nxt = '0;
      else                                            nxt = decode();
      if (write_back) mreg[dest_wb] = result_wb;
    end
    @(posedge clk);
    #1;
    exp_st = nxt;
    chk("ex_state", act, exp_st);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        z;
    logic        valid, wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] rn, rm;
    logic [3:0]  rd;
    logic        two;
    logic [3:0]  s2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    rst = 1; in_valid = 1; PC_in = 32'h1234; instruction = $urandom;
    stall = 0; flush = 0; hazard = 0; {Z, N, C, V} = 4'b1111;
    write_back = 1; dest_wb = 4'd3; result_wb = 32'hDEAD;
    exp_st = '0;
    for (int i = 0; i < 16; i++) mreg[i] = 'x;

    // reset with arbitrary inputs
    for (int i = 0; i < 2; i++) begin
      instruction = $urandom;
      tick();
      chk("reset_state", act, 0);
    end
    rst = 0; write_back = 0; {Z, N, C, V} = 4'b0000;

    // every register reads back 0 after reset
    for (int i = 0; i < 16; i++) begin
      instruction = 32'hE080_0000 | (i << 16) | i;
      tick();
      chk("reset_rn", ex_val_Rn, 0);
      chk("reset_rm", ex_val_Rm, 0);
    end

    // preload R2..R5 behind bubbles
    in_valid = 0; write_back = 1;
    dest_wb = 2; result_wb = 5;     tick();
    dest_wb = 3; result_wb = 7;     tick();
    dest_wb = 4; result_wb = 32'h44; tick();
    dest_wb = 5; result_wb = 32'h55; tick();
    write_back = 0; in_valid = 1;

    vecs[0] = '{32'hE0821003, 0, 1,1,0,0,0,0, 4'd2, 5, 7, 4'd1, 1, 4'd3};     // ADD R1,R2,R3
    vecs[1] = '{32'hE5854000, 0, 1,0,0,1,0,0, 4'd2, 32'h55, 32'h44, 4'd4, 1, 4'd4}; // STR R4,[R5]
    vecs[2] = '{32'hE5956000, 0, 1,1,1,0,0,0, 4'd2, 32'h55, 0, 4'd6, 1, 4'd0};  // LDR R6,[R5]
    vecs[3] = '{32'hE3A07005, 0, 1,1,0,0,0,0, 4'd1, 0, 32'h55, 4'd7, 0, 4'd5};  // MOV R7,#5
    vecs[4] = '{32'hE1520003, 0, 1,0,0,0,0,1, 4'd4, 5, 7, 4'd0, 1, 4'd3};      // CMP R2,R3
    vecs[5] = '{32'h00821003, 0, 0,0,0,0,0,0, 4'd0, 0, 0, 4'd0, 1, 4'd3};      // ADDEQ, Z=0
    vecs[6] = '{32'h00821003, 1, 1,1,0,0,0,0, 4'd2, 5, 7, 4'd1, 1, 4'd3};      // ADDEQ, Z=1
    vecs[7] = '{32'hEA000010, 0, 1,0,0,0,1,0, 4'd0, 0, 0, 4'd0, 0, 4'd0};      // B

    for (int i = 0; i < 8; i++) begin
      instruction = vecs[i].instr;
      Z = vecs[i].z;
      PC_in = 32'h100 + 4 * i;
      #1;
      chk("vec_two_src", two_src, vecs[i].two);
      chk("vec_src2", src2, vecs[i].s2);
      tick();
      chk("vec_ctrl", {ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_B, ex_S, ex_exec_cmd},
          {vecs[i].valid, vecs[i].wb, vecs[i].mr, vecs[i].mw, vecs[i].b, vecs[i].s, vecs[i].cmd});
      chk("vec_data", {ex_val_Rn, ex_val_Rm, ex_Rd}, {vecs[i].rn, vecs[i].rm, vecs[i].rd});
    end
    Z = 0;

    // same-cycle WB write to R2 is seen by the decode
    instruction = 32'hE0821003; write_back = 1; dest_wb = 2; result_wb = 32'h99;
    tick();
    chk("bypass_rn", ex_val_Rn, 32'h99);
    write_back = 0;

    // stall holds for 3 cycles while the instruction changes
    instruction = 32'hE0821003; PC_in = 32'h200; tick();
    snap = act;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      instruction = $urandom; PC_in = $urandom;
      tick();
      chk("stall_hold", act, snap);
    end
    flush = 1;
    tick();
    chk("stall_flush_valid", ex_valid, 0);
    flush = 0; stall = 0;

    // hazard inserts a bubble, but not while stalled
    instruction = 32'hE0821003; hazard = 1; tick();
    chk("hazard_bubble", ex_valid, 0);
    hazard = 0; tick();
    chk("hazard_reload", ex_valid, 1);
    stall = 1; hazard = 1; tick();
    chk("hazard_in_stall", ex_valid, 1);
    stall = 0; hazard = 0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] cnd;
      cnd = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rst         = ($urandom_range(0, 199) == 0);
      in_valid    = ($urandom_range(0, 9) != 0);
      instruction = {cnd, 28'($urandom)};
      PC_in       = $urandom;
      stall       = ($urandom_range(0, 6) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      hazard      = ($urandom_range(0, 6) == 0);
      {Z, N, C, V} = 4'($urandom);
      write_back  = $urandom_range(0, 1);
      dest_wb     = 4'($urandom);
      result_wb   = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
